// File: rtl/fetch_unit.sv
// Instruction prefetch stage: issues word fetches on a req/ack bus, buffers
// returned words with their PCs in a small FIFO, and flushes on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h10000000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_fetch_pc, w_fetch_pc_next;
    logic          r_bus_req, w_bus_req_next;
    logic [31:0]   r_bus_addr, w_bus_addr_next;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_push;
    logic          w_push, w_pop;
    logic [31:0]   w_pc_plus4, w_redirect_pc;

    assign w_pc_plus4    = r_fetch_pc + 32'd4;
    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign o_instr_valid = (r_count != '0);
    assign w_pop         = o_instr_valid & i_instr_ready & ~i_redirect;
    // Occupancy after an accepted fetch lands this edge; decides whether to refetch.
    assign w_count_push  = r_count + (AW + 1)'(1) - {{AW{1'b0}}, w_pop};

    assign o_bus_req  = r_bus_req;
    assign o_bus_addr = r_bus_addr;
    assign o_instr    = r_mem_instr[r_rd_ptr];
    assign o_instr_pc = r_mem_pc[r_rd_ptr];

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_bus_req_next  = r_bus_req;
        w_bus_addr_next = r_bus_addr;
        w_push          = 1'b0;
        if (i_redirect) begin
            w_fetch_pc_next = w_redirect_pc;
            // An outstanding fetch must still complete; its data is discarded.
            if (r_state != S_IDLE) begin
                if (i_bus_ack) begin
                    w_state_next   = S_IDLE;
                    w_bus_req_next = 1'b0;
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < FULL) begin
                        w_state_next    = S_WAIT;
                        w_bus_req_next  = 1'b1;
                        w_bus_addr_next = r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (i_bus_ack) begin
                        w_push          = 1'b1;
                        w_fetch_pc_next = w_pc_plus4;
                        if (w_count_push < FULL) begin
                            w_bus_addr_next = w_pc_plus4;
                        end else begin
                            w_state_next   = S_IDLE;
                            w_bus_req_next = 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_bus_ack) begin
                        w_state_next   = S_IDLE;
                        w_bus_req_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next   = S_IDLE;
                    w_bus_req_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_bus_req  <= 1'b0;
            r_bus_addr <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_bus_req  <= w_bus_req_next;
            r_bus_addr <= w_bus_addr_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_mem_instr[gi] <= 32'h0;
                    r_mem_pc[gi]    <= 32'h0;
                end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem_instr[gi] <= i_bus_rdata;
                    r_mem_pc[gi]    <= r_bus_addr;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, hand sequences for redirect/reset
// corners, then random bus/consumer traffic against an instruction-stream model.
module tb_fetch_unit;
    localparam logic [31:0] K = 32'hA5A50000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_bus_req;
    logic [31:0] o_bus_addr;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = 32'h0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;

    int n_pass = 0;
    int n_total = 0;

    fetch_unit dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
        .i_instr_ready(i_instr_ready),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic a, input logic r, input logic d, input logic [31:0] rp,
                                input logic q, input logic [31:0] ad, input logic v, input logic [31:0] p);
        vec_t x;
        x.ack = a; x.rdy = r; x.redir = d; x.rpc = rp;
        x.req = q; x.addr = ad; x.valid = v; x.pc = p;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        logic [31:0] exp_pc, prev_addr;
        logic        prev_req, prev_ack, prev_redir;
        int          wait_cnt, pops;

        // ready=0 fill to 4, pop re-arms fetch, streaming, redirect-with-ack, wrap
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10000000, 1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10000004, 1'b1, 32'h10000000);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10000008, 1'b1, 32'h10000000);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000000C, 1'b1, 32'h10000000);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 32'h10000000);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 32'h10000000);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 32'h10000004);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10000010, 1'b1, 32'h10000004);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 32'h10000004);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 32'h10000008);
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10000014, 1'b1, 32'h1000000C);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10000018, 1'b1, 32'h10000010);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1000001C, 1'b1, 32'h10000014);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10000020, 1'b1, 32'h10000018);
        tbl[14] = mk(1'b1, 1'b1, 1'b1, 32'h30000000, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30000000, 1'b0, 32'h0);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30000004, 1'b1, 32'h30000000);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h30000008, 1'b1, 32'h30000004);
        tbl[18] = mk(1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[19] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0);
        tbl[20] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000000, 1'b1, 32'hFFFFFFFC);
        tbl[21] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000004, 1'b1, 32'h00000000);
        tbl[22] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000008, 1'b1, 32'h00000004);

        repeat (3) @(negedge i_clk);
        chk("rst_req", {31'h0, o_bus_req}, 32'h0);
        chk("rst_addr", o_bus_addr, 32'h0);
        chk("rst_valid", {31'h0, o_instr_valid}, 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_pc", o_instr_pc, 32'h0);
        i_rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            i_bus_ack     = tbl[i].ack;
            i_bus_rdata   = o_bus_addr ^ K;
            i_instr_ready = tbl[i].rdy;
            i_redirect    = tbl[i].redir;
            i_redirect_pc = tbl[i].rpc;
            step();
            $display("vec %0d: req=%b addr=%h valid=%b pc=%h", i, o_bus_req, o_bus_addr, o_instr_valid, o_instr_pc);
            chk($sformatf("vec%0d_req", i), {31'h0, o_bus_req}, {31'h0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("vec%0d_addr", i), o_bus_addr, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, o_instr_valid}, {31'h0, tbl[i].valid});
            if (tbl[i].valid) begin
                chk($sformatf("vec%0d_pc", i), o_instr_pc, tbl[i].pc);
                chk($sformatf("vec%0d_instr", i), o_instr, tbl[i].pc ^ K);
            end
        end

        // Asynchronous reset while a fetch is outstanding
        i_bus_ack = 1'b0; i_instr_ready = 1'b0; i_redirect = 1'b0;
        #1 i_rst = 1'b1;
        #1;
        $display("async reset: req=%b addr=%h valid=%b", o_bus_req, o_bus_addr, o_instr_valid);
        chk("arst_req", {31'h0, o_bus_req}, 32'h0);
        chk("arst_addr", o_bus_addr, 32'h0);
        chk("arst_valid", {31'h0, o_instr_valid}, 32'h0);
        chk("arst_instr", o_instr, 32'h0);
        chk("arst_pc", o_instr_pc, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step();
        chk("arst_first_req", {31'h0, o_bus_req}, 32'h1);
        chk("arst_first_addr", o_bus_addr, 32'h10000000);

        // Redirect while the ack is held off for 3 cycles: stale word dropped
        i_bus_ack = 1'b1; i_bus_rdata = o_bus_addr ^ K;
        step();
        chk("drn_pre_valid", {31'h0, o_instr_valid}, 32'h1);
        chk("drn_pre_pc", o_instr_pc, 32'h10000000);
        i_bus_ack = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h20000043;
        step();
        i_redirect = 1'b0;
        for (int w = 0; w < 3; w++) begin
            $display("drain cycle %0d: req=%b addr=%h valid=%b", w, o_bus_req, o_bus_addr, o_instr_valid);
            chk("drn_valid", {31'h0, o_instr_valid}, 32'h0);
            chk("drn_req", {31'h0, o_bus_req}, 32'h1);
            chk("drn_addr", o_bus_addr, 32'h10000004);
            i_bus_ack = (w == 2);
            i_bus_rdata = o_bus_addr ^ K;
            step();
        end
        i_bus_ack = 1'b0;
        chk("drn_ack_req", {31'h0, o_bus_req}, 32'h0);
        chk("drn_ack_valid", {31'h0, o_instr_valid}, 32'h0);
        step();
        chk("drn_new_req", {31'h0, o_bus_req}, 32'h1);
        chk("drn_new_addr", o_bus_addr, 32'h20000040);
        chk("drn_new_valid", {31'h0, o_instr_valid}, 32'h0);
        i_bus_ack = 1'b1; i_bus_rdata = o_bus_addr ^ K;
        step();
        chk("drn_head_valid", {31'h0, o_instr_valid}, 32'h1);
        chk("drn_head_pc", o_instr_pc, 32'h20000040);
        chk("drn_head_instr", o_instr, 32'h20000040 ^ K);

        // Random traffic: popped stream must be consecutive words from the last target
        i_bus_ack = 1'b0; i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        exp_pc = 32'h10000000; wait_cnt = 0; pops = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b0; prev_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_redir) chk("rnd_flush", {31'h0, o_instr_valid}, 32'h0);
            if (prev_req && !prev_ack) begin
                chk("rnd_req_hold", {31'h0, o_bus_req}, 32'h1);
                chk("rnd_addr_hold", o_bus_addr, prev_addr);
            end
            if (o_bus_req) begin
                if (wait_cnt == 0) begin
                    i_bus_ack = 1'b1;
                    i_bus_rdata = o_bus_addr ^ K;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    i_bus_ack = 1'b0;
                    wait_cnt--;
                end
            end else begin
                i_bus_ack = ($urandom_range(0, 7) == 0);
                i_bus_rdata = $urandom;
            end
            i_instr_ready = ($urandom_range(0, 3) != 0);
            i_redirect    = ($urandom_range(0, 19) == 0);
            i_redirect_pc = $urandom;
            if (o_instr_valid && i_instr_ready && !i_redirect) begin
                chk("rnd_pc", o_instr_pc, exp_pc);
                chk("rnd_instr", o_instr, exp_pc ^ K);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (i_redirect) exp_pc = {i_redirect_pc[31:2], 2'b00};
            prev_redir = i_redirect;
            prev_req   = o_bus_req;
            prev_ack   = i_bus_ack;
            prev_addr  = o_bus_addr;
            step();
        end
        $display("random phase: %0d instructions consumed", pops);
        chk("rnd_progress", {31'h0, pops > 500}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
